// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO with direction, atomic set/clr/tgl, synchronised inputs and rising-edge irq.
module gpio_bank #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'd32,
  parameter logic [4:0]  STR_UOP     = 5'd9,
  parameter logic [4:0]  LDR_UOP     = 5'd8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       uop,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic             irq
);
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, ien_q, ien_d, stat_q, stat_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] in_w, rise, wd, rsel;
  logic [31:0] off;
  logic [2:0] idx;
  logic dec, st;
  always_comb begin
    off = addr - BASE_ADDR;
    dec = addr >= BASE_ADDR && off < 32'd32 && addr[1:0] == 2'b00;
    idx = off[4:2];
    st = dec && uop == STR_UOP;
    hit = dec && (uop == STR_UOP || uop == LDR_UOP);
    wd = wdata[WIDTH-1:0];
    in_w = sync_q[SYNC_STAGES-1];
    // the last stage doubles as edge history, so a flag sets on the edge IN changes
    rise = sync_q[SYNC_STAGES-2] & ~in_w;
    sync_d = {sync_q[SYNC_STAGES-2:0], gpio_in};
    out_d = !st ? out_q :
            idx == 3'd0 ? wd :
            idx == 3'd2 ? out_q | wd :
            idx == 3'd3 ? out_q & ~wd :
            idx == 3'd4 ? out_q ^ wd : out_q;
    dir_d = st && idx == 3'd1 ? wd : dir_q;
    ien_d = st && idx == 3'd6 ? wd : ien_q;
    stat_d = (stat_q & ~(st && idx == 3'd7 ? wd : '0)) | rise;
    rsel = idx == 3'd0 ? out_q :
           idx == 3'd1 ? dir_q :
           idx == 3'd5 ? in_w :
           idx == 3'd6 ? ien_q :
           idx == 3'd7 ? stat_q : '0;
    rdata = dec && uop == LDR_UOP ? 32'(rsel) : '0;
    gpio_out = out_q;
    gpio_oe = dir_q;
    irq = |(stat_q & ien_q);
  end
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      out_q <= '0;
      dir_q <= '0;
      ien_q <= '0;
      stat_q <= '0;
      sync_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      ien_q <= ien_d;
      stat_q <= stat_d;
      sync_q <= sync_d;
    end
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and random checks of gpio_bank against a register-map model.
module tb_gpio_bank;
  localparam logic [31:0] BASE = 32'd32;
  localparam logic [4:0] STR = 5'd9, LDR = 5'd8;
  localparam int SS = 2;
  logic clk = 0, rst_n = 0;
  logic [4:0] uop = 0;
  logic [31:0] addr = 0, wdata = 0, gpio_in = 0;
  logic [31:0] gpio_out, gpio_oe, rdata, rdata8;
  logic [7:0] gpio_out8, gpio_oe8;
  logic hit, irq, hit8, irq8;
  int n_chk = 0, n_fail = 0;
  gpio_bank dut (
    .clk(clk), .rst_n(rst_n), .uop(uop), .addr(addr), .wdata(wdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .rdata(rdata), .hit(hit), .irq(irq)
  );
  gpio_bank #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .uop(uop), .addr(addr), .wdata(wdata), .gpio_in(gpio_in[7:0]),
    .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .rdata(rdata8), .hit(hit8), .irq(irq8)
  );
  always #5 clk = ~clk;
  logic [31:0] m_out = 0, m_dir = 0, m_ien = 0, m_stat = 0, o_in, w1c;
  logic [31:0] hist[$];
  function automatic logic [31:0] m_in();
    return hist.size() >= SS ? hist[hist.size() - SS] : 32'd0;
  endfunction
  function automatic bit dec();
    return addr >= BASE && addr - BASE < 32'd32 && addr[1:0] == 2'b00;
  endfunction
  function automatic int oidx();
    return int'((addr - BASE) >> 2);
  endfunction
  function automatic logic [31:0] m_rdata();
    if (uop != LDR || !dec()) return 32'd0;
    case (oidx())
      0: return m_out;
      1: return m_dir;
      5: return m_in();
      6: return m_ien;
      7: return m_stat;
      default: return 32'd0;
    endcase
  endfunction
  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      m_out = 0; m_dir = 0; m_ien = 0; m_stat = 0;
      hist.delete();
    end else begin
      o_in = m_in();
      w1c = 0;
      if (uop == STR && dec())
        case (oidx())
          0: m_out = wdata;
          1: m_dir = wdata;
          2: m_out = m_out | wdata;
          3: m_out = m_out & ~wdata;
          4: m_out = m_out ^ wdata;
          6: m_ien = wdata;
          7: w1c = wdata;
          default: ;
        endcase
      hist.push_back(gpio_in);
      if (hist.size() > 8) void'(hist.pop_front());
      m_stat = (m_stat & ~w1c) | (m_in() & ~o_in);
    end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    chk("out", gpio_out, m_out);
    chk("oe", gpio_oe, m_dir);
    chk("irq", 32'(irq), 32'(|(m_stat & m_ien)));
    chk("rdata", rdata, m_rdata());
    chk("hit", 32'(hit), 32'((uop == STR || uop == LDR) && dec()));
    chk("out8", 32'(gpio_out8), m_out & 32'hFF);
    chk("oe8", 32'(gpio_oe8), m_dir & 32'hFF);
    chk("irq8", 32'(irq8), 32'(|(m_stat & m_ien & 32'hFF)));
    chk("rdata8", rdata8, m_rdata() & 32'hFF);
    chk("hit8", 32'(hit8), 32'(hit));
  end
  task automatic op(input logic [4:0] u, input logic [31:0] a, input logic [31:0] w);
    @(posedge clk);
    #1 uop = u; addr = a; wdata = w;
    @(negedge clk);
    #1;
  endtask
  initial begin
    #1_000_000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk); #1;
    chk("rst_out", gpio_out, 0);
    chk("rst_oe", gpio_oe, 0);
    chk("rst_irq", 32'(irq), 0);
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      op(LDR, BASE + 32'(4 * k), 0);
      chk("rst_ldr", rdata, 0);
    end
    op(STR, BASE, 32'hF0);       chk("str_out", gpio_out, 32'hF0);
    op(STR, BASE + 8, 32'h0F);   chk("set", gpio_out, 32'hFF);
    op(STR, BASE + 12, 32'h81);  chk("clr", gpio_out, 32'h7E);
    op(STR, BASE + 16, 32'hFF);  chk("tgl", gpio_out, 32'h81);
    op(LDR, BASE + 8, 0);        chk("ldr_set", rdata, 0); chk("ldr_set_hit", 32'(hit), 1);
    op(STR, BASE + 8, 0);        chk("set_zero", gpio_out, 32'h81);
    op(STR, BASE + 24, 32'h8);
    gpio_in = 32'h8;
    op(LDR, BASE + 20, 0);       chk("in_edge1", rdata, 0); chk("irq_edge1", 32'(irq), 0);
    op(LDR, BASE + 20, 0);       chk("in_edge2", rdata, 32'h8); chk("irq_edge2", 32'(irq), 1);
    op(LDR, BASE + 28, 0);       chk("stat", rdata, 32'h8); chk("ldr_keeps", 32'(irq), 1);
    op(STR, BASE + 28, 32'h8);   chk("w1c_irq", 32'(irq), 0);
    gpio_in = 0;
    op(0, 0, 0); op(0, 0, 0);
    op(LDR, BASE + 28, 0);       chk("fall_noflag", rdata, 0);
    gpio_in = 32'h1;
    op(0, 0, 0); op(0, 0, 0);
    gpio_in = 0;
    op(0, 0, 0); op(0, 0, 0);
    op(LDR, BASE + 28, 0);       chk("stat0_set", rdata, 32'h1); chk("masked_irq", 32'(irq), 0);
    gpio_in = 32'h1;
    op(0, 0, 0);
    op(STR, BASE + 28, 32'h1);
    op(LDR, BASE + 28, 0);       chk("rise_wins", rdata, 32'h1);
    op(STR, BASE + 28, 32'h1);
    op(LDR, BASE + 28, 0);       chk("w1c_clears", rdata, 0);
    op(STR, BASE + 2, 32'h1234); chk("unaligned_hit", 32'(hit), 0); chk("unaligned_out", gpio_out, 32'h81);
    op(STR, BASE + 32, 32'h1234); chk("oob_hit", 32'(hit), 0); chk("oob_out", gpio_out, 32'h81);
    op(STR, 32'd0, 32'h1234);    chk("below_hit", 32'(hit), 0); chk("below_out", gpio_out, 32'h81);
    @(posedge clk);
    #1 uop = STR; addr = BASE; wdata = 32'h55;
    #2 rst_n = 0;
    #1 chk("midrst_now", gpio_out, 0);
    @(negedge clk);
    #1 rst_n = 1; uop = 0;
    chk("midrst_lost", gpio_out, 0);
    op(STR, BASE, 32'hFFFF_FFFF); chk("w8_out", 32'(gpio_out8), 32'hFF); chk("w32_out", gpio_out, 32'hFFFF_FFFF);
    op(LDR, BASE, 0);             chk("w8_rdata", rdata8, 32'hFF);
    for (int i = 0; i < 800; i++) begin
      int r, k;
      r = $urandom_range(0, 3);
      k = $urandom_range(0, 11);
      @(posedge clk);
      #1 uop = r == 1 ? LDR : r == 3 ? 5'($urandom_range(0, 31)) : STR;
      addr = BASE + 32'(4 * k) + ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 32'd0);
      wdata = $urandom;
      if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ ($urandom & $urandom & $urandom);
    end
    @(posedge clk);
    #1 uop = 0;
    @(posedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised memory-mapped GPIO bank in the execute stage. Successor to the single-output-register GPIO.
- Adds per-pin direction control and atomic SET/CLR/TGL writes.
- Adds a synchronised input path with rising-edge interrupt capture, plus LDR read-back of all registers.
- Decodes the same uop/addr bus as the D-Cache and drives the pad-level output, output-enable and irq.

Parameters:
WIDTH, 32, number of pins (1..32); register bits above WIDTH-1 read 0 and ignore writes
BASE_ADDR, 32'd32, byte address of register 0
STR_UOP, 5'd9, uop code for store
LDR_UOP, 5'd8, uop code for load
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  input  1  clock; all state updates on falling edge
rst_n  input  1  asynchronous active-low reset
uop  input  5  micro-op from execute
addr  input  32  byte address
wdata  input  32  store data
gpio_in  input  WIDTH  asynchronous pad inputs
gpio_out  output  WIDTH  OUT register
gpio_oe  output  WIDTH  DIR register (1 = drive)
rdata  output  32  load data, combinational
hit  output  1  uop is STR_UOP/LDR_UOP and addr in BASE_ADDR..BASE_ADDR+28, word aligned
irq  output  1  |(IRQ_STAT & IRQ_EN)

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 OUT rw
  - 4 DIR rw
  - 8 SET wo: OUT |= wdata
  - 12 CLR wo: OUT &= ~wdata
  - 16 TGL wo: OUT ^= wdata
  - 20 IN ro: synchronised pins
  - 24 IRQ_EN rw
  - 28 IRQ_STAT: reads sticky flags; write-1-to-clear
- Address decode:
  - Unaligned addresses (addr[1:0] != 0) or addresses outside the map: no write, rdata = 0, hit = 0.
  - Writes to ro/wo-only offsets are ignored. Reads of SET/CLR/TGL return 0.
- Reset (rst_n low, asynchronous):
  - OUT, DIR, IRQ_EN, IRQ_STAT, all synchroniser stages and the edge-history register clear to 0.
  - Outputs: gpio_out = 0, gpio_oe = 0, irq = 0. rdata follows the cleared state.
  - Reset asserted mid-store discards the store.
- Writes:
  - Take effect on the falling edge of clk while uop == STR_UOP and addr decodes.
  - gpio_out/gpio_oe change on that same edge, i.e. visible for the following cycle.
- Input path:
  - gpio_in passes through SYNC_STAGES flops. IN reads the last stage.
  - prev register holds the previous IN value.
  - rise = IN & ~prev.
  - Pin change to IN visible: SYNC_STAGES falling edges.
  - Pin change to IRQ_STAT set: SYNC_STAGES falling edges (set on the edge where rise is seen).
  - irq is combinational from the registers.
- IRQ_STAT update per bit each edge: next = (stat & ~w1c) | rise.
  - A new rise wins over a simultaneous W1C of the same bit.
  - Flags capture regardless of IRQ_EN (enable masks irq only).
- Loads:
  - rdata is valid in the same cycle when uop == LDR_UOP and addr decodes, otherwise 0.
  - A load of IRQ_STAT does not clear it.
- DIR does not gate IN: IN always reflects pins, including driven ones.
- SET/CLR/TGL with wdata = 0 leave OUT unchanged.

Test Plan:
- Reset check: rst_n low -> gpio_out = 0, gpio_oe = 0, irq = 0. Release, LDR each offset -> rdata = 0.
- Direct and atomic writes to OUT:
  - STR OUT 0x0000_00F0 -> gpio_out = 0xF0.
  - STR SET 0x0F -> 0xFF.
  - STR CLR 0x81 -> 0x7E.
  - STR TGL 0xFF -> 0x81.
  - LDR SET -> rdata = 0.
- Input path: gpio_in[3] 0->1 with IRQ_EN = 0x8.
  - IN[3] reads 1 after 2 falling edges.
  - IRQ_STAT = 0x8 and irq = 1 on that same edge.
  - STR IRQ_STAT 0x8 -> irq = 0. A falling pin sets nothing.
- Same-edge W1C vs rise: IRQ_STAT[0] set; STR IRQ_STAT 0x1 on the exact edge where a new rise on pin 0 is detected -> IRQ_STAT[0] stays 1.
- Decode misses and mid-op reset:
  - STR to BASE_ADDR+2 (unaligned) or BASE_ADDR+32 -> no register changes, hit = 0.
  - rst_n pulsed low mid-cycle with STR OUT pending -> gpio_out = 0 immediately, store lost.
- WIDTH = 8 instance: STR OUT 0xFFFF_FFFF -> gpio_out = 0xFF, LDR OUT -> rdata = 0x0000_00FF.
